// File: rtl/delay_probe.sv
// Purpose : launches a pattern into a delay path and measures echo latency in clocks.
// Latency : drive updates 1 clk after an accepted start; done pulses (delay+1) clks after that.
// Backpr. : none; start is only accepted in IDLE and is dropped while busy or reporting.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    measurement request, sampled only in IDLE
//   pattern  value to launch, sampled together with start
//   drive    registered value fed into the path under test
//   echo     output of the path under test, sampled every clock
//   busy     high while waiting for the echo
//   done     one-cycle pulse when delay/timeout/stale are valid
//   delay    measured latency in cycles (holds until next start)
//   timeout  no match within MAX_DELAY (holds until next start)
//   stale    echo already matched pattern when start was accepted
//
// MAX_DELAY must fit in CW bits (MAX_DELAY <= 2**CW - 1); the counter
// saturates at MAX_DELAY and is never allowed to wrap.

module delay_probe #(
   parameter int WIDTH     = 4,
   parameter int MAX_DELAY = 15,
   parameter int CW        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   output logic [WIDTH-1:0] drive,
   input  logic [WIDTH-1:0] echo,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    delay,
   output logic             timeout,
   output logic             stale
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DELAY);

   state_t           state;
   logic [WIDTH-1:0] pattern_q;
   logic [CW-1:0]    cnt;

   // Single registered FSM: every output is a flop updated here.
   // cnt holds the number of WAIT edges already seen without a match, so a
   // match on the first WAIT edge (combinational loopback) reports 0 and a
   // path with N flops between drive and echo reports N.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         drive     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         delay     <= '0;
         timeout   <= 1'b0;
         stale     <= 1'b0;
         pattern_q <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  pattern_q <= pattern;
                  drive     <= pattern;
                  cnt       <= '0;
                  delay     <= '0;
                  timeout   <= 1'b0;
                  // The path already shows the new value before we launch it;
                  // the result is flagged but the measurement still runs.
                  stale     <= (echo == pattern);
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end

            WAIT: begin
               // Match is tested first so a match on the final allowed edge
               // is still reported as a real latency rather than a timeout.
               if (echo == pattern_q) begin
                  delay   <= cnt;
                  timeout <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= REPORT;
               end else if (cnt == MAX_CNT) begin
                  delay   <= MAX_CNT;
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= REPORT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            REPORT: begin
               // Start is deliberately ignored here; the requester must
               // present it again once the block is back in IDLE.
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_probe.sv
// Bench for delay_probe: models the path under test (loopback, N-flop
// pipeline or constant echo), predicts each result into a queue when a
// start is launched, and pops/compares when done is observed.

module tb_delay_probe;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] pattern;
   logic [3:0] drive;
   logic [3:0] echo;
   logic       busy;
   logic       done;
   logic [3:0] delay;
   logic       timeout;
   logic       stale;

   delay_probe #(.WIDTH(4), .MAX_DELAY(15), .CW(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .pattern (pattern),
      .drive   (drive),
      .echo    (echo),
      .busy    (busy),
      .done    (done),
      .delay   (delay),
      .timeout (timeout),
      .stale   (stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Path model: 0 = combinational loopback, 1 = pipeline of depth flops,
   // 2 = constant value.
   int         mode;
   int         depth;
   logic [3:0] const_v;
   logic [2:0] pipe_sel;
   logic [3:0] pipe [0:7];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) pipe[i] <= 4'h0;
      end else begin
         pipe[0] <= drive;
         for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb begin
      pipe_sel = 3'(depth - 1);
      case (mode)
         0:       echo = drive;
         1:       echo = pipe[pipe_sel];
         default: echo = const_v;
      endcase
   end

   typedef struct {
      logic [3:0] delay;
      logic       timeout;
      logic       stale;
      int         cycles;
   } exp_t;

   exp_t       sb [$];
   int         checks;
   int         passes;
   logic [3:0] last_drive;

   // Expected result for launching p with the path settled on last_drive.
   function automatic exp_t model(input logic [3:0] p);
      exp_t e;
      logic [3:0] settled;
      settled = (mode == 2) ? const_v : last_drive;
      e.stale = (settled == p);
      if (e.stale) begin
         e.delay   = 4'd0;
         e.timeout = 1'b0;
      end else if (mode == 2 || (mode == 1 && depth > 15)) begin
         e.delay   = 4'd15;
         e.timeout = 1'b1;
      end else begin
         e.delay   = (mode == 0) ? 4'd0 : 4'(depth);
         e.timeout = 1'b0;
      end
      e.cycles = int'(e.delay) + 1;
      return e;
   endfunction

   task automatic idle(input int n);
      start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; launches p, optionally injects a stray start
   // during WAIT (at WAIT cycle inj_wait) and/or REPORT, then checks the
   // popped prediction. Returns on the negedge after REPORT (block in IDLE).
   task automatic measure(input logic [3:0] p, input int inj_wait, input bit inj_report);
      exp_t e;
      int   n;
      int   busy_n;
      bit   seen;
      sb.push_back(model(p));
      start   = 1'b1;
      pattern = p;
      @(negedge clk);
      n = 0; busy_n = 0; seen = 0;
      while (!seen && n < 40) begin
         if (busy) busy_n++;
         if (done) begin
            seen = 1;
         end else begin
            start   = (n == inj_wait);
            pattern = (n == inj_wait) ? 4'h3 : ~p;
            @(negedge clk);
            n++;
         end
      end
      start = 1'b0;
      checks++;
      if (!seen) begin
         $display("FAIL done_wait p=%h: no done within 40 cycles, required one", p);
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         passes++;
         e = sb.pop_front();
         checks++; if (delay !== e.delay)
            $display("FAIL delay p=%h: got %0d want %0d", p, delay, e.delay); else passes++;
         checks++; if (timeout !== e.timeout)
            $display("FAIL timeout p=%h: got %b want %b", p, timeout, e.timeout); else passes++;
         checks++; if (stale !== e.stale)
            $display("FAIL stale p=%h: got %b want %b", p, stale, e.stale); else passes++;
         checks++; if (n !== e.cycles)
            $display("FAIL done_cycle p=%h: got %0d want %0d", p, n, e.cycles); else passes++;
         checks++; if (busy_n !== e.cycles)
            $display("FAIL busy_len p=%h: got %0d want %0d", p, busy_n, e.cycles); else passes++;
         checks++; if (drive !== p)
            $display("FAIL drive p=%h: got %h want %h", p, drive, p); else passes++;
      end
      last_drive = p;
      if (inj_report) begin
         start   = 1'b1;
         pattern = 4'h3;
      end
      @(negedge clk);
      start = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL done_pulse p=%h: done=%b busy=%b want 0 0", p, done, busy); else passes++;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; pattern = 4'hF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (drive !== 4'h0) $display("FAIL reset_drive: got %h want 0", drive); else passes++;
      checks++; if ({busy, done, timeout, stale} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {busy, done, timeout, stale}); else passes++;
      checks++; if (delay !== 4'h0) $display("FAIL reset_delay: got %h want 0", delay); else passes++;
      last_drive = 4'h0;
   endtask

   task automatic test_loopback;
      mode = 0; idle(2);
      measure(4'hA, -1, 0);
   endtask

   task automatic test_pipeline;
      mode = 1; depth = 3; idle(8);
      measure(4'h5, -1, 0);
      idle(2);
      checks++; if (drive !== 4'h5) $display("FAIL pipe_hold: got %h want 5", drive); else passes++;
      idle(6);
      measure(4'hC, -1, 0);
   endtask

   task automatic test_timeout;
      mode = 2; const_v = 4'h0; idle(2);
      measure(4'h7, -1, 0);
   endtask

   task automatic test_ignored_start;
      bit extra;
      mode = 1; depth = 2; idle(8);
      measure(4'h9, 0, 1);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy || done || drive !== 4'h9) extra = 1;
         @(negedge clk);
      end
      checks++; if (extra) $display("FAIL ignored_start: second measurement seen, drive=%h want 9", drive);
      else passes++;
   endtask

   task automatic test_stale;
      mode = 2; const_v = 4'h6; idle(2);
      measure(4'h6, -1, 0);
   endtask

   task automatic test_reset_mid;
      bit spurious;
      mode = 1; depth = 5; idle(8);
      start = 1'b1; pattern = 4'hB;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", busy); else passes++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (drive !== 4'h0) $display("FAIL rstmid_drive: got %h want 0", drive); else passes++;
      checks++; if ({busy, done, timeout} !== 3'b000)
         $display("FAIL rstmid_flags: got %b want 000", {busy, done, timeout}); else passes++;
      checks++; if (delay !== 4'h0) $display("FAIL rstmid_delay: got %h want 0", delay); else passes++;
      spurious = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) spurious = 1;
      end
      checks++; if (spurious) $display("FAIL rstmid_nodone: done/busy after reset, want none"); else passes++;
      last_drive = 4'h0;
   endtask

   task automatic test_back_to_back;
      mode = 1; depth = 1; idle(4);
      measure(4'h3, -1, 0);
      measure(4'hD, -1, 0);
      measure(4'h8, -1, 0);
      checks++; if (sb.size() !== 0) $display("FAIL sb_empty: got %0d left want 0", sb.size()); else passes++;
   endtask

   initial begin
      checks = 0; passes = 0;
      mode = 0; depth = 1; const_v = 4'h0; last_drive = 4'h0;
      rst = 1'b1; start = 1'b0; pattern = 4'h0;
      test_reset;
      test_loopback;
      test_pipeline;
      test_timeout;
      test_ignored_start;
      test_stale;
      test_reset_mid;
      test_back_to_back;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passes, checks);
      $fatal(1);
   end

endmodule

// File: doc/delay_probe.md
Name: delay_probe

Overview:
- Stimulus side and measurement side of a registered delay path (a nibble-wide delay line or any DUT that echoes its input after N clocks).
- On a start request it drives a new pattern into the path. It then counts clock edges until the echoed value matches that pattern and reports the latency, or a timeout.
- Used on bench and on chip to characterise pipeline and delay-line latency in cycles.

Parameters:
- WIDTH, 4, width of pattern, drive and echo buses
- MAX_DELAY, 15, largest latency measured before timeout; must be ≤ 2^CW − 1
- CW, 4, width of the delay result counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  measurement request; sampled only in IDLE
- pattern  input  WIDTH  value to launch; sampled with start
- drive  output  WIDTH  registered value fed into the path under test
- echo  input  WIDTH  output of the path under test; sampled every clk
- busy  output  1  high while a measurement is in WAIT
- done  output  1  one-cycle pulse when the result is valid
- delay  output  CW  measured latency in cycles; holds until next start
- timeout  output  1  high with done if no match within MAX_DELAY; holds until next start
- stale  output  1  high if echo already equaled pattern when start was accepted; holds until next start

Behaviour:
- Clock and reset:
  - Single clock domain; all outputs registered.
  - rst sampled on posedge clk overrides everything.
  - Reset values: state=IDLE, drive=0, busy=0, done=0, delay=0, timeout=0, stale=0, internal pattern_q=0, cnt=0.
- States: IDLE, WAIT, REPORT.
- IDLE:
  - drive holds its last value.
  - At edge E0 with start=1:
    - pattern_q<=pattern, drive<=pattern, cnt<=0.
    - delay<=0, timeout<=0.
    - stale<=(echo==pattern); measurement still proceeds.
    - busy<=1, state<=WAIT.
  - start=0 keeps the block in IDLE.
- WAIT (edges E1, E2, …):
  - If echo==pattern_q: delay<=cnt, timeout<=0, busy<=0, done<=1, state<=REPORT.
  - Else if cnt==MAX_DELAY: delay<=MAX_DELAY, timeout<=1, busy<=0, done<=1, state<=REPORT.
  - Else cnt<=cnt+1.
  - Match has priority over timeout on the same edge.
- Latency meaning:
  - Delay = number of flops between drive and echo.
  - Combinational loopback gives 0; one register gives 1; N registers give N.
- REPORT:
  - done=1 for exactly one cycle; next edge done<=0, state<=IDLE.
  - A start asserted during REPORT is ignored; it must be re-asserted in IDLE.
- Start handling:
  - start while busy or in REPORT has no effect; pattern changes in those states are ignored.
  - Back-to-back measurements: the minimum start-to-start spacing is latency+3 cycles.
- cnt saturation: cnt never exceeds MAX_DELAY and never wraps.
- Reset mid-operation: rst in WAIT or REPORT returns to IDLE with reset values, drive=0, and no done pulse.
- Widths:
  - Equality compare is across the full WIDTH.
  - delay is zero-extended from cnt.

Test Plan:
- Combinational loopback, start with pattern=4'hA from drive=0 → done one cycle after E1; delay=0, timeout=0, stale=0; busy high for exactly 1 cycle.
- Three-register pipeline, pattern=4'h5 → delay=3, done at E4+1, drive=4'h5 held afterward; repeat with pattern=4'hC → delay=3 again.
- Echo tied to 4'h0, pattern=4'h7, MAX_DELAY=15 → done after 16 WAIT edges; timeout=1, delay=15.
- Start pulsed with 4'h3 during WAIT of a 2-cycle path measuring 4'h9 → result delay=2 for 4'h9; no second measurement starts; drive stays 4'h9.
- Echo already 4'h6 (unchanged path output), start with pattern=4'h6 → stale=1, delay=0, done asserted.
- rst asserted on the 2nd WAIT cycle of a 5-cycle path → next cycle state IDLE, drive=0, busy=0; no done pulse; delay=0, timeout=0.
